// File: rtl/snitch_refill_responder.sv
// ============================================================================
// snitch_refill_responder_pkg
//   Default AXI4 channel and bundle types for the refill responder: 32-bit
//   address, 32-bit data, 4-bit ID, 1-bit user. Only the channel fields the
//   responder uses are carried.
// ============================================================================
package snitch_refill_responder_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

`default_nettype none

// ============================================================================
// snitch_refill_responder
//   AXI4 read-only subordinate in front of a request/grant memory. Each AR
//   burst becomes a stream of single-word memory reads whose results are
//   returned as R beats through a small response FIFO. WRAP bursts and
//   oversized beats are answered with SLVERR beats without touching memory.
//   Writes are drained and answered with a single SLVERR B response.
//
//   Ports
//     clk_i          clock
//     rst_ni         asynchronous reset, active low
//     axi_slv_req_i  AXI request bundle from the refill initiator
//     axi_slv_rsp_o  AXI response bundle to the refill initiator
//     mem_req_o      memory read request (accepted on req & gnt)
//     mem_gnt_i      memory grant
//     mem_addr_o     word-aligned byte address
//     mem_rvalid_i   read data valid (in order, cannot be stalled)
//     mem_rdata_i    read data
//     mem_err_i      read error, qualified by mem_rvalid_i
//
//   Revision: 1.0 - initial release
// ============================================================================
module snitch_refill_responder #(
  parameter int unsigned AxiAddrWidth = snitch_refill_responder_pkg::AddrWidth,
  parameter int unsigned AxiDataWidth = snitch_refill_responder_pkg::DataWidth,
  parameter int unsigned AxiIdWidth   = snitch_refill_responder_pkg::IdWidth,
  parameter int unsigned AxiUserWidth = snitch_refill_responder_pkg::UserWidth,
  parameter int unsigned RspDepth     = 4,
  parameter type axi_req_t = snitch_refill_responder_pkg::axi_req_t,
  parameter type axi_rsp_t = snitch_refill_responder_pkg::axi_rsp_t
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  axi_req_t                axi_slv_req_i,
  output axi_rsp_t                axi_slv_rsp_o,
  output logic                    mem_req_o,
  input  logic                    mem_gnt_i,
  output logic [AxiAddrWidth-1:0] mem_addr_o,
  input  logic                    mem_rvalid_i,
  input  logic [AxiDataWidth-1:0] mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int unsigned OffsetBits = $clog2(AxiDataWidth / 8);
  localparam int unsigned PtrWidth   = (RspDepth > 1) ? $clog2(RspDepth) : 1;
  localparam int unsigned CntWidth   = $clog2(RspDepth + 1);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  localparam logic [AxiAddrWidth-1:0] AlignMask =
    ~AxiAddrWidth'((64'd1 << OffsetBits) - 64'd1);

  localparam logic [1:0] RdIdle     = 2'd0;
  localparam logic [1:0] RdRead     = 2'd1;
  localparam logic [1:0] RdErrBurst = 2'd2;

  localparam logic [1:0] WrIdle = 2'd0;
  localparam logic [1:0] WrData = 2'd1;
  localparam logic [1:0] WrResp = 2'd2;

  // --------------------------------------------------------------------------
  // Read path state
  // --------------------------------------------------------------------------
  logic [1:0]              rd_state, rd_state_next;
  logic [AxiIdWidth-1:0]   rd_id;
  logic [AxiAddrWidth-1:0] rd_addr;
  logic [7:0]              rd_len;
  logic [2:0]              rd_size;
  logic [1:0]              rd_burst;
  logic [8:0]              issued;    // memory requests granted
  logic [8:0]              received;  // memory responses accepted into the FIFO
  logic [8:0]              beats;     // R beats handed to the initiator

  logic [AxiDataWidth-1:0] fifo_data [RspDepth];
  logic                    fifo_err  [RspDepth];
  logic [PtrWidth-1:0]     wptr, rptr;
  logic [CntWidth-1:0]     fifo_count;

  logic                    ar_ready, ar_hs, ar_bad;
  logic                    r_valid, r_hs, r_last;
  logic [AxiDataWidth-1:0] r_data;
  logic [1:0]              r_resp;
  logic                    mem_hs, push, pop, credit;
  logic [8:0]              len_plus1;
  logic [31:0]             in_use;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RspDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign ar_hs     = axi_slv_req_i.ar_valid & ar_ready;
  assign ar_bad    = (axi_slv_req_i.ar.burst == BurstWrap) ||
                     (32'(axi_slv_req_i.ar.size) > OffsetBits);
  assign r_hs      = r_valid & axi_slv_req_i.r_ready;
  assign r_last    = (beats == {1'b0, rd_len});
  assign len_plus1 = {1'b0, rd_len} + 9'd1;
  assign mem_hs    = mem_req_o & mem_gnt_i;

  // Every slot that is outstanding at the memory or parked in the FIFO counts
  // against the FIFO depth, so an unstallable response always has room.
  assign in_use = 32'(issued - received) + 32'(fifo_count);
  assign credit = (in_use < RspDepth);

  // Responses are only accepted while a burst has reads outstanding; anything
  // still in flight across a reset finds nothing outstanding and is dropped.
  assign push = mem_rvalid_i && (rd_state == RdRead) && (issued != received);
  assign pop  = r_hs && (rd_state == RdRead);

  assign mem_addr_o = rd_addr & AlignMask;

  // Read FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state <= RdIdle;
    end else begin
      rd_state <= rd_state_next;
    end
  end

  // Read FSM: next state
  always_comb begin
    rd_state_next = rd_state;
    case (rd_state)
      RdIdle: begin
        if (ar_hs) begin
          rd_state_next = ar_bad ? RdErrBurst : RdRead;
        end
      end
      RdRead, RdErrBurst: begin
        if (r_hs && r_last) begin
          rd_state_next = RdIdle;
        end
      end
      default: rd_state_next = RdIdle;
    endcase
  end

  // Read FSM: outputs
  always_comb begin
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = RespOkay;
    mem_req_o = 1'b0;
    case (rd_state)
      RdIdle: begin
        ar_ready = 1'b1;
      end
      RdRead: begin
        mem_req_o = (issued < len_plus1) && credit;
        r_valid   = (fifo_count != '0);
        r_data    = fifo_data[rptr];
        r_resp    = fifo_err[rptr] ? RespSlvErr : RespOkay;
      end
      RdErrBurst: begin
        r_valid = 1'b1;
        r_resp  = RespSlvErr;
      end
      default: ;
    endcase
  end

  // Burst context and beat counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_id    <= '0;
      rd_addr  <= '0;
      rd_len   <= '0;
      rd_size  <= '0;
      rd_burst <= '0;
      issued   <= '0;
      received <= '0;
      beats    <= '0;
    end else if (ar_hs) begin
      rd_id    <= axi_slv_req_i.ar.id;
      rd_addr  <= axi_slv_req_i.ar.addr;
      rd_len   <= axi_slv_req_i.ar.len;
      rd_size  <= axi_slv_req_i.ar.size;
      rd_burst <= axi_slv_req_i.ar.burst;
      issued   <= '0;
      received <= '0;
      beats    <= '0;
    end else begin
      if (mem_hs) begin
        issued <= issued + 9'd1;
        if (rd_burst != BurstFixed) begin
          rd_addr <= rd_addr + (AxiAddrWidth'(1) << rd_size);
        end
      end
      if (push) begin
        received <= received + 9'd1;
      end
      if (r_hs) begin
        beats <= beats + 9'd1;
      end
    end
  end

  // Response FIFO (registered output, not fall-through)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wptr <= ptr_inc(wptr);
      end
      if (pop) begin
        rptr <= ptr_inc(rptr);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CntWidth'(1);
        2'b01:   fifo_count <= fifo_count - CntWidth'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data[wptr] <= mem_rdata_i;
      fifo_err[wptr]  <= mem_err_i;
    end
  end

  // --------------------------------------------------------------------------
  // Write path: drain AW/W, answer SLVERR
  // --------------------------------------------------------------------------
  logic [1:0]            wr_state, wr_state_next;
  logic [AxiIdWidth-1:0] wr_id;
  logic                  aw_ready, w_ready, b_valid;
  logic                  aw_hs;

  assign aw_hs = axi_slv_req_i.aw_valid & aw_ready;

  // Write FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state <= WrIdle;
      wr_id    <= '0;
    end else begin
      wr_state <= wr_state_next;
      if (aw_hs) begin
        wr_id <= axi_slv_req_i.aw.id;
      end
    end
  end

  // Write FSM: next state
  always_comb begin
    wr_state_next = wr_state;
    case (wr_state)
      WrIdle: if (aw_hs) wr_state_next = WrData;
      WrData: if (axi_slv_req_i.w_valid && axi_slv_req_i.w.last) wr_state_next = WrResp;
      WrResp: if (axi_slv_req_i.b_ready) wr_state_next = WrIdle;
      default: wr_state_next = WrIdle;
    endcase
  end

  // Write FSM: outputs
  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (wr_state)
      WrIdle:  aw_ready = 1'b1;
      WrData:  w_ready  = 1'b1;
      WrResp:  b_valid  = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Response bundle
  // --------------------------------------------------------------------------
  logic [AxiUserWidth-1:0] zero_user;
  assign zero_user = '0;

  always_comb begin
    axi_slv_rsp_o          = '0;
    axi_slv_rsp_o.ar_ready = ar_ready;
    axi_slv_rsp_o.r_valid  = r_valid;
    axi_slv_rsp_o.r.id     = rd_id;
    axi_slv_rsp_o.r.data   = r_data;
    axi_slv_rsp_o.r.resp   = r_resp;
    axi_slv_rsp_o.r.last   = r_last;
    axi_slv_rsp_o.r.user   = zero_user;
    axi_slv_rsp_o.aw_ready = aw_ready;
    axi_slv_rsp_o.w_ready  = w_ready;
    axi_slv_rsp_o.b_valid  = b_valid;
    axi_slv_rsp_o.b.id     = wr_id;
    axi_slv_rsp_o.b.resp   = RespSlvErr;
    axi_slv_rsp_o.b.user   = zero_user;
  end

  // Write payload is accepted and discarded.
  logic unused_bits;
  assign unused_bits = ^{axi_slv_req_i.aw.addr, axi_slv_req_i.aw.len,
                         axi_slv_req_i.aw.size, axi_slv_req_i.aw.burst,
                         axi_slv_req_i.w.data, axi_slv_req_i.w.strb};

endmodule

`default_nettype wire

// File: tb/tb_snitch_refill_responder.sv
`default_nettype none

// ============================================================================
// tb_snitch_refill_responder
//   Self-checking bench: a 1-cycle-latency memory with optional grant stalls,
//   directed timing/boundary scenarios and randomized bursts compared against
//   a burst-level reference model.
//
//   Revision: 1.0 - initial release
// ============================================================================
module tb_snitch_refill_responder;
  import snitch_refill_responder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  axi_req_t    req;
  axi_rsp_t    rsp;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] err_addr;
  logic [31:0] granted_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  snitch_refill_responder #(
    .AxiAddrWidth(32), .AxiDataWidth(32), .AxiIdWidth(4), .AxiUserWidth(1),
    .RspDepth(DEPTH), .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .axi_slv_req_i(req), .axi_slv_rsp_o(rsp),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Memory: fixed 1-cycle read latency, records every granted address.
  always @(posedge clk) begin
    mem_rvalid <= mem_req && mem_gnt;
    mem_rdata  <= mem_fn(mem_addr);
    mem_err    <= (mem_addr == err_addr);
    if (mem_req === 1'b1 && mem_gnt === 1'b1) granted_q.push_back(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":ready"}, {rsp.ar_ready, rsp.aw_ready, rsp.w_ready}, 3'b110);
    check({tag, ":valid"}, {rsp.r_valid, rsp.b_valid}, 2'b00);
    check({tag, ":mem"}, {mem_req, mem_addr}, 33'h0);
  endtask

  // One AR burst with randomized handshakes, checked beat by beat against a
  // model built from the burst rules. Called and returns on a falling edge.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int rready_pct,
                           input int gnt_pct, input int hold, input string tag);
    logic [31:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic [31:0] exp_addr[$];
    logic [31:0] a;
    bit          errb;
    int          n, beats, cyc, held;
    errb = (burst == 2'b10) || (size > 3'd2);
    for (int i = 0; i <= int'(len); i++) begin
      if (errb) begin
        exp_data.push_back(32'h0);
        exp_resp.push_back(2'b10);
      end else begin
        a = (burst == 2'b00) ? addr : addr + i * (32'd1 << size);
        a[1:0] = 2'b00;
        exp_addr.push_back(a);
        exp_data.push_back(mem_fn(a));
        exp_resp.push_back((a == err_addr) ? 2'b10 : 2'b00);
      end
    end
    granted_q.delete();
    req.ar.id = id; req.ar.addr = addr; req.ar.len = len;
    req.ar.size = size; req.ar.burst = burst; req.ar_valid = 1'b1;
    n = 0;
    while (!rsp.ar_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, ":ar_accept"}, rsp.ar_ready, 1);
    @(negedge clk);
    req.ar_valid = 1'b0;
    beats = 0; cyc = 0;
    while (beats <= int'(len) && cyc < 5000) begin
      mem_gnt = ($urandom_range(99) < gnt_pct);
      req.r_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rready_pct);
      if (hold > 0 && cyc == hold) begin
        held = (int'(len) + 1 < DEPTH) ? int'(len) + 1 : DEPTH;
        check({tag, ":held_reqs"}, granted_q.size(), held);
        check({tag, ":held_req_low"}, mem_req, 0);
      end
      if (rsp.r_valid && req.r_ready) begin
        check({tag, ":beat"}, {rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last},
              {id, exp_data[beats], exp_resp[beats], (beats == int'(len))});
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    req.r_ready = 1'b0;
    check({tag, ":beats_done"}, beats, int'(len) + 1);
    check({tag, ":ar_ready_after"}, rsp.ar_ready, 1);
    check({tag, ":req_count"}, granted_q.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < granted_q.size(); i++)
      check($sformatf("%s:addr%0d", tag, i), granted_q[i], exp_addr[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] obs_v, exp_v;
    req = '0; mem_gnt = 1'b1; err_addr = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("post_reset");

    // Cycle-exact INCR burst: addr 0x100, len 3, size 2, r_ready held high.
    req.r_ready = 1'b1; mem_gnt = 1'b1; granted_q.delete();
    req.ar.id = 4'h3; req.ar.addr = 32'h100; req.ar.len = 8'd3;
    req.ar.size = 3'd2; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      obs_v = {rsp.ar_ready, mem_req, (mem_req ? mem_addr : 32'h0),
               rsp.r_valid, rsp.r_valid & rsp.r.last};
      exp_v = {(k == 7), (k <= 4), ((k <= 4) ? 32'h100 + 32'(4 * (k - 1)) : 32'h0),
               (k >= 3 && k <= 6), (k == 6)};
      check($sformatf("timing_c%0d", k), obs_v, exp_v);
      if (k >= 3 && k <= 6)
        check($sformatf("timing_beat_c%0d", k), {rsp.r.id, rsp.r.data, rsp.r.resp},
              {4'h3, mem_fn(32'h100 + 32'(4 * (k - 3))), 2'b00});
      @(negedge clk);
    end
    req.r_ready = 1'b0;

    // Credit stall: r_ready low for 10 cycles, only DEPTH reads may issue.
    run_burst(4'h4, 32'h100, 8'd7, 3'd2, 2'b01, 100, 100, 10, "stall");
    run_burst(4'h2, 32'h40, 8'd2, 3'd2, 2'b00, 100, 100, 0, "fixed");
    run_burst(4'h1, 32'h80, 8'd1, 3'd2, 2'b10, 100, 100, 0, "wrap");
    run_burst(4'h7, 32'h80, 8'd1, 3'd3, 2'b01, 100, 100, 0, "size3");
    run_burst(4'h0, 32'h200, 8'd0, 3'd2, 2'b01, 60, 60, 0, "len0");

    err_addr = 32'h504;
    run_burst(4'h6, 32'h500, 8'd3, 3'd2, 2'b01, 100, 100, 0, "memerr");
    err_addr = 32'hFFFF_FFFF;

    // Write burst in parallel with a read burst, AW and AR in the same cycle.
    check("par_both_ready", {rsp.ar_ready, rsp.aw_ready}, 2'b11);
    fork
      begin : wr_side
        int n;
        req.aw.id = 4'h5; req.aw.addr = 32'h1000; req.aw.len = 8'd2;
        req.aw.size = 3'd2; req.aw.burst = 2'b01; req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
          req.w.data = $urandom; req.w.strb = 4'hF;
          req.w.last = (i == 2); req.w_valid = 1'b1;
          n = 0;
          while (!rsp.w_ready && n < 50) begin @(negedge clk); n++; end
          @(negedge clk);
        end
        req.w_valid = 1'b0; req.w.last = 1'b0;
        n = 0;
        while (!rsp.b_valid && n < 50) begin @(negedge clk); n++; end
        check("wr_b", {rsp.b_valid, rsp.b.id, rsp.b.resp}, {1'b1, 4'h5, 2'b10});
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        check("wr_b_done", {rsp.b_valid, rsp.aw_ready}, 2'b01);
      end
      run_burst(4'h9, 32'h300, 8'd5, 3'd2, 2'b01, 70, 80, 0, "par_rd");
    join

    run_burst(4'hA, 32'h2000, 8'd255, 3'd2, 2'b01, 90, 90, 0, "len255");

    for (int t = 0; t < 12; t++)
      run_burst(4'($urandom), $urandom, 8'($urandom_range(0, 20)),
                3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                $urandom_range(30, 100), $urandom_range(30, 100), 0,
                $sformatf("rand%0d", t));

    // Reset mid-burst with a memory response still in flight at release.
    req.r_ready = 1'b0; mem_gnt = 1'b1;
    req.ar.id = 4'hB; req.ar.addr = 32'h700; req.ar.len = 8'd15;
    req.ar.size = 3'd2; req.ar.burst = 2'b01; req.ar_valid = 1'b1;
    @(negedge clk);
    req.ar_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pre_active", {mem_req, rsp.r_valid}, 2'b11);
    rst_n = 1'b0;
    #1 check_reset("rst_mid");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst_release");
    @(negedge clk);
    check_reset("rst_settled");
    run_burst(4'hC, 32'h800, 8'd4, 3'd2, 2'b01, 80, 80, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snitch_refill_responder.md
# snitch_refill_responder

AXI4 read-only subordinate that serves the cache-line refill bursts issued by the constant/instruction cache refill path. It sits at the far end of that AXI port, in front of a simple request/grant memory (SRAM or ROM macro). It turns each AR burst into a sequence of single-word memory reads and returns the results as R beats. Writes are not supported and are answered with SLVERR.

## Interface
- AxiAddrWidth, 0: AXI and memory address width; must be set.
- AxiDataWidth, 0: AXI and memory data width; must be ≥ 32 and a power of two.
- AxiIdWidth, 0: AXI ID width.
- AxiUserWidth, 0: AXI user width; R/B user outputs are tied to 0.
- RspDepth, 4: response FIFO depth; also the maximum number of reads in flight. Must be ≥ 2.
- axi_req_t, logic: AXI request struct type.
- axi_rsp_t, logic: AXI response struct type.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- axi_slv_req_i  in  axi_req_t  AXI request from the refill initiator.
- axi_slv_rsp_o  out  axi_rsp_t  AXI response to the refill initiator.
- mem_req_o  out  1  memory read request.
- mem_gnt_i  in  1  memory grant; a request is accepted when req & gnt.
- mem_addr_o  out  AxiAddrWidth  word-aligned byte address.
- mem_rvalid_i  in  1  read data valid. Responses are in order; rvalid cannot be stalled.
- mem_rdata_i  in  AxiDataWidth  read data.
- mem_err_i  in  1  read error, qualified by mem_rvalid_i.

## Operation
Read FSM states: Idle, Read, ErrBurst.

- **Idle**
  - ar_ready = 1.
  - On AR handshake, latch id, addr, len, size and burst, and clear the issue and return beat counters.
  - Go to ErrBurst if burst == WRAP, or if size > log2(AxiDataWidth/8). Otherwise go to Read.
- **Read (issue side)**
  - mem_req_o = 1 while issued < len+1 and credits are available.
  - Credits are available when (issued − returned) + FIFO occupancy < RspDepth.
  - mem_addr_o = addr with the low log2(AxiDataWidth/8) bits zeroed.
  - On each grant: INCR adds (1 << size) to addr, modulo 2^AxiAddrWidth (no 4 KiB check; the initiator is responsible). FIXED leaves addr unchanged.
- **Read (return side)**
  - Each mem_rvalid_i pushes {rdata, err} into the FIFO.
  - R beat fields: data = FIFO head, resp = SLVERR if err else OKAY, id = latched id, user = 0.
  - last = 1 when the return counter == latched len.
  - r_valid = FIFO not empty.
  - On the handshake of the last beat, go to Idle.
- **ErrBurst**
  - Emit len+1 R beats with resp = SLVERR, data = 0 and last on the final beat. No memory access.
  - Go to Idle on the handshake of the last beat.
- Only one read burst is handled at a time. AR is not accepted until the last R beat of the current burst has been accepted.

Write FSM states: WIdle, WData, WResp.

- WIdle: aw_ready = 1. On handshake, latch id and go to WData.
- WData: w_ready = 1. On a handshake with wlast, go to WResp.
- WResp: b_valid = 1, b.resp = SLVERR, b.id = latched id. On handshake, go to WIdle.
- The memory is never written.

## Timing
- Reset values:
  - ar_ready = 1, aw_ready = 1.
  - r_valid = 0, b_valid = 0, w_ready = 0.
  - mem_req_o = 0, mem_addr_o = 0.
  - FIFO empty, counters 0, both FSMs idle.
- Latency:
  - AR handshake in cycle 0 → mem_req_o asserted in cycle 1.
  - With 1-cycle memory latency, grant in cycle 1 → rvalid in cycle 2 → first r_valid in cycle 3. The FIFO is not fall-through.
- Throughput is 1 beat/cycle sustained when RspDepth ≥ memory latency + 2 and r_ready is held high.
- r_ready low: issue stalls when credits run out. mem_rvalid_i is never dropped.
- r_valid and R payload are held stable until the handshake (AXI rule).
- len = 0: a single beat with last = 1.
- len = 255: 256 beats. The counters are 9 bits wide so that len+1 does not overflow.
- AR and AW in the same cycle: both are accepted in the same cycle; the read and write paths are independent.
- Reset mid-burst: everything is discarded immediately. Memory responses still in flight after reset release are ignored, because the credit count is 0 and the return path is idle.

## Test plan
- AR INCR, addr 0x100, len 3, size 2 (32-bit bus), memory latency 1, r_ready = 1:
  - mem_addr 0x100, 0x104, 0x108, 0x10C in cycles 1–4.
  - Four OKAY beats in cycles 3–6, last on the 4th, id echoed.
  - ar_ready back to 1 in cycle 7.
- Same burst, r_ready = 0 for 10 cycles: exactly RspDepth mem requests issued, then mem_req_o = 0. All four beats are delivered in order once r_ready rises.
- AR FIXED, addr 0x40, len 2: three requests, all to 0x40. Three beats, last on the 3rd.
- AR WRAP, len 1: no mem_req_o. Two SLVERR beats with data 0.
- AR size 3 on a 32-bit bus: treated the same way (no memory access, SLVERR beats).
- mem_err_i on the 2nd of 4 beats: that beat has resp SLVERR and the others OKAY. The burst completes normally.
- AW id 5 plus 3 W beats (wlast on the 3rd) in parallel with an AR burst:
  - One B, SLVERR, id 5.
  - Read data unaffected.
  - rst_ni pulsed mid-burst returns all outputs to their reset values.
